alu_seq: RTL and testbench

- Parametrised, registered, multi-cycle successor to the team's 32-bit combinational ALU.
- Keeps the same 4-bit op_code map and the equal/overflow/zero flags.
- Adds a valid/ready handshake on input and output, a WIDTH parameter, and iterative one-bit-per-cycle shifts with back-pressure.
- Sits between the datapath register file and writeback in the multi-cycle CPU.

---
 rtl/alu_seq.sv | 147 ++++++++++++++
 tb/tb_alu_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with valid/ready handshakes and one-bit-per-cycle shifts.
// Optional `ALU_MUL_EN turns op 4 into an iterative unsigned shift-add multiply.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             equal,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t state, state_next;
    logic [WIDTH-1:0] work, alu_z, add_r, sub_r, shifted;
    logic [SHAMT_W:0] cnt;
    logic [1:0] sh_op;
    logic eq_p, alu_ov, out_free, accept, is_shift, is_mul, done;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand, hi;
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, hi} + (work[0] ? {1'b0, mcand} : '0);
    assign is_mul = op_code == 4'd4;
`else
    assign is_mul = 1'b0;
`endif
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept = in_valid && in_ready;
    assign busy = state != IDLE;
    assign done = (cnt == '0) && out_free;
    assign is_shift = op_code inside {4'd8, 4'd9, 4'd10};
    assign add_r = X + Y;
    assign sub_r = X - Y;
    // sh_op is op_code[1:0]: 0 SRL, 1 SLL, 2 SRA
    assign shifted = sh_op == 2'd0 ? {1'b0, work[WIDTH-1:1]} :
                     sh_op == 2'd1 ? {work[WIDTH-2:0], 1'b0} :
                                     {work[WIDTH-1], work[WIDTH-1:1]};

    always_comb begin
        alu_z = '0;
        alu_ov = 1'b0;
        case (op_code)
            4'd0: alu_z = X & Y;
            4'd1: alu_z = X | Y;
            4'd2: alu_z = X ^ Y;
            4'd3: alu_z = ~(X | Y);
            4'd5: begin
                alu_z = add_r;
                alu_ov = (X[WIDTH-1] == Y[WIDTH-1]) && (add_r[WIDTH-1] != X[WIDTH-1]);
            end
            4'd6: begin
                alu_z = sub_r;
                alu_ov = (X[WIDTH-1] != Y[WIDTH-1]) && (sub_r[WIDTH-1] != X[WIDTH-1]);
            end
            4'd7: alu_z = {{(WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (accept && is_shift) state_next = SHIFT;
`ifdef ALU_MUL_EN
            else if (accept && is_mul) state_next = MUL;
`endif
        end else if (done) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Z <= '0;
            equal <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
            work <= '0;
            cnt <= '0;
            sh_op <= '0;
            eq_p <= 1'b0;
`ifdef ALU_MUL_EN
            mcand <= '0;
            hi <= '0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                eq_p <= X == Y;
                sh_op <= op_code[1:0];
                work <= X;
                cnt <= {1'b0, Y[SHAMT_W-1:0]};
`ifdef ALU_MUL_EN
                if (is_mul) begin
                    work <= Y;
                    mcand <= X;
                    hi <= '0;
                    cnt <= (SHAMT_W+1)'(WIDTH);
                end
`endif
                if (!is_shift && !is_mul) begin
                    Z <= alu_z;
                    equal <= X == Y;
                    overflow <= alu_ov;
                    zero <= alu_z == '0;
                    out_valid <= 1'b1;
                end
            end else if (state != IDLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
`ifdef ALU_MUL_EN
                // multiplier shifts out of work's LSB while product bits shift in from hi
                if (state == MUL) {hi, work} <= {mul_sum, work[WIDTH-1:1]};
                else work <= shifted;
`else
                work <= shifted;
`endif
            end else if (state != IDLE && out_free) begin
                Z <= work;
                equal <= eq_p;
                zero <= work == '0;
                out_valid <= 1'b1;
`ifdef ALU_MUL_EN
                overflow <= (state == MUL) && (hi != '0);
`else
                overflow <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; a monitor pops expected results on each output transfer.
module tb_alu_seq;
    logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [31:0] X = 0, Y = 0, Z;
    logic [3:0] op_code = 0;
    logic equal, overflow, zero, busy;
    int total = 0, passed = 0, next_id = 0;

    typedef struct {
        logic [31:0] z;
        logic eq;
        logic ov;
        logic zr;
        int id;
    } exp_t;
    exp_t sb[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .equal(equal), .overflow(overflow), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got Z=0x%0h with no expected result queued", Z);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (Z === e.z && equal === e.eq && overflow === e.ov && zero === e.zr) passed++;
                else $display("FAIL result_%0d: got Z=0x%0h eq=%b ov=%b zero=%b, required Z=0x%0h eq=%b ov=%b zero=%b",
                              e.id, Z, equal, overflow, zero, e.z, e.eq, e.ov, e.zr);
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op, input bit push,
                         input logic [31:0] ez, input logic eeq, input logic eov, input logic ezr, output int waits);
        exp_t e;
        if (push) begin
            e.z = ez; e.eq = eeq; e.ov = eov; e.zr = ezr; e.id = next_id++;
            sb.push_back(e);
        end
        in_valid = 1; X = x; Y = y; op_code = op;
        waits = 0;
        while (waits < 200) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
        end
        if (waits >= 200) check(0, "accept_timeout", 32'(waits), 0);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_out(output int m, output bit ir_seen);
        m = 0;
        ir_seen = 0;
        while (!out_valid && m < 200) begin
            if (in_ready) ir_seen = 1;
            @(posedge clk);
            #1 m++;
        end
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                       input logic [31:0] ez, input logic eeq, input logic eov, input logic ezr,
                       input int exp_m, input string name);
        int w, m;
        bit irs;
        issue(x, y, op, 1, ez, eeq, eov, ezr, w);
        wait_out(m, irs);
        check(m == exp_m, {name, "_latency"}, 32'(m), 32'(exp_m));
    endtask

    initial begin
        int w, m;
        bit irs, bad;
        #12;
        check(!out_valid && Z == 0 && !equal && !overflow && !zero && !busy && in_ready, "reset_state",
              {Z[27:0], out_valid, busy, zero, in_ready}, 32'h1);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        run(32'h7FFFFFFF, 32'h1, 4'd5, 32'h80000000, 0, 1, 0, 0, "add_ovf");
        issue(32'h1234, 32'h1234, 4'd6, 1, 32'h0, 1, 0, 1, w);
        issue(32'hF0F0, 32'h0FF0, 4'd0, 1, 32'h00F0, 0, 0, 0, w);
        check(w == 0, "back_to_back_wait", 32'(w), 0);
        run(32'hF0F0, 32'h0FF0, 4'd1, 32'hFFF0, 0, 0, 0, 0, "or");
        run(32'hF0F0, 32'h0FF0, 4'd2, 32'hFF00, 0, 0, 0, 0, "xor");
        run(32'hF0F0, 32'h0FF0, 4'd3, 32'hFFFF000F, 0, 0, 0, 0, "nor");
        run(32'hFFFFFFFF, 32'h1, 4'd7, 32'h1, 0, 0, 0, 0, "slt_neg");
        run(32'h5, 32'h3, 4'd7, 32'h0, 0, 0, 1, 0, "slt_pos");
        run(32'h80000000, 32'h1, 4'd6, 32'h7FFFFFFF, 0, 1, 0, 0, "sub_ovf");
        run(32'hFFFFFFFF, 32'h1, 4'd5, 32'h0, 0, 0, 1, 0, "add_wrap");

        issue(32'h80000000, 32'd31, 4'd10, 1, 32'hFFFFFFFF, 0, 0, 0, w);
        wait_out(m, irs);
        check(m == 32, "sra_latency", 32'(m), 32);
        check(!irs, "sra_in_ready_low", 32'(irs), 0);
        run(32'hDEADBEEF, 32'h0, 4'd8, 32'hDEADBEEF, 0, 0, 0, 1, "srl_k0");
        run(32'hF0000000, 32'h24, 4'd8, 32'h0F000000, 0, 0, 0, 5, "srl_hi_y");
        run(32'h3, 32'h3, 4'd15, 32'h0, 1, 0, 1, 0, "op15");
`ifdef ALU_MUL_EN
        run(32'h10000, 32'h10000, 4'd4, 32'h0, 1, 1, 1, 33, "mul_big");
        run(32'h7, 32'h6, 4'd4, 32'd42, 0, 0, 0, 33, "mul_small");
`else
        run(32'h7, 32'h6, 4'd4, 32'h0, 0, 0, 1, 0, "op4");
`endif
        @(posedge clk); #1 out_ready = 0;
        issue(32'h1, 32'h4, 4'd9, 1, 32'h10, 0, 0, 0, w);
        wait_out(m, irs);
        check(m == 5, "sll_latency", 32'(m), 5);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Z !== 32'h10 || !out_valid || in_ready) bad = 1;
        end
        check(!bad, "backpressure_hold", Z, 32'h10);
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1;
        check(!out_valid && in_ready, "after_transfer", {30'b0, out_valid, in_ready}, 32'h1);

        issue(32'h1, 32'd20, 4'd9, 0, 0, 0, 0, 0, w);
        repeat (5) @(posedge clk);
        #2;
        check(busy, "mid_shift_busy", 32'(busy), 1);
        rst = 1;
        #1;
        check(!out_valid && !busy && Z == 0, "async_reset", Z, 0);
        @(negedge clk) rst = 0;
        @(negedge clk);
        check(in_ready && !out_valid, "ready_after_reset", 32'(in_ready), 1);
        repeat (3) @(posedge clk);
        check(sb.size() == 0, "scoreboard_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
